// File: rtl/edge_pulse_array_if.sv
// Bundles the per-channel level inputs, edge mode, flag clears and pulse/flag
// outputs of edge_pulse_array.
interface edge_pulse_array_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] input_signal;
    logic [1:0]          mode;
    logic [CHANNELS-1:0] clear_flags;
    logic [CHANNELS-1:0] output_signal;
    logic [CHANNELS-1:0] edge_flags;
    logic                any_pulse;

    modport master (
        output input_signal, mode, clear_flags,
        input  output_signal, edge_flags, any_pulse
    );

    modport slave (
        input  input_signal, mode, clear_flags,
        output output_signal, edge_flags, any_pulse
    );
endinterface

// File: rtl/edge_pulse_array.sv
// Multi-channel edge-to-pulse generator: optional synchroniser and debounce per
// channel, selectable edge mode, retriggerable stretched pulses, sticky flags.
module edge_pulse_array #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int PULSE_LEN       = 1
) (
    input  logic            clk,
    input  logic            rst,
    edge_pulse_array_if.slave bus
);

    localparam int N  = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int CW = $clog2(N) + 1;
    localparam int PW = $clog2(PULSE_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
    localparam logic [PW-1:0] PCNT_LOAD = PW'(PULSE_LEN - 1);

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] d_vec;
    logic [CHANNELS-1:0] d_prev_reg;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] evt;
    logic [CHANNELS-1:0] pulse_next;
    logic [CHANNELS-1:0] pulse_reg;
    logic [CHANNELS-1:0] flag_reg;
    logic                any_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic          d_reg;
            logic [CW-1:0] cnt_reg;
            logic [PW-1:0] pcnt_reg;

            if (SYNC_STAGES == 0) begin : g_nosync
                assign s[gi] = bus.input_signal[gi];
            end else begin : g_sync
                logic [SYNC_STAGES-1:0] sync_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg <= '0;
                    end else begin
                        sync_reg <= SYNC_STAGES'({sync_reg, bus.input_signal[gi]});
                    end
                end
                assign s[gi] = sync_reg[SYNC_STAGES-1];
            end

            // A new level is accepted only after it has differed from d for N cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_reg   <= 1'b0;
                    cnt_reg <= '0;
                end else if (s[gi] == d_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    d_reg   <= s[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // An event reloads the stretch counter, so retriggers extend without a gap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pcnt_reg <= '0;
                end else if (evt[gi]) begin
                    pcnt_reg <= PCNT_LOAD;
                end else if (pcnt_reg != '0) begin
                    pcnt_reg <= pcnt_reg - 1'b1;
                end
            end

            assign d_vec[gi]      = d_reg;
            assign pulse_next[gi] = evt[gi] | (pcnt_reg != '0);
        end
    endgenerate

    assign rise = d_vec & ~d_prev_reg;
    assign fall = ~d_vec & d_prev_reg;

    always_comb begin
        evt = '0;
        case (bus.mode)
            2'b00:   evt = rise;
            2'b01:   evt = fall;
            2'b10:   evt = rise | fall;
            default: evt = '0;
        endcase
    end

    // Set takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_prev_reg <= '0;
            pulse_reg  <= '0;
            flag_reg   <= '0;
            any_reg    <= 1'b0;
        end else begin
            d_prev_reg <= d_vec;
            pulse_reg  <= pulse_next;
            flag_reg   <= evt | (flag_reg & ~bus.clear_flags);
            any_reg    <= |pulse_next;
        end
    end

    assign bus.output_signal = pulse_reg;
    assign bus.edge_flags    = flag_reg;
    assign bus.any_pulse     = any_reg;

endmodule

// File: tb/tb_edge_pulse_array.sv
// Scoreboard bench for edge_pulse_array: three instances cover default timing,
// debounce and pulse stretching; expectations are derived from edge latencies.
module tb_edge_pulse_array;

    typedef struct {
        int         edge_no;
        logic [8:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    sb_t  sb[$];

    edge_pulse_array_if #(.CHANNELS(4)) ifa ();
    edge_pulse_array_if #(.CHANNELS(4)) ifb ();
    edge_pulse_array_if #(.CHANNELS(4)) ifc ();

    edge_pulse_array #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .PULSE_LEN(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    edge_pulse_array #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_LEN(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    edge_pulse_array #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .PULSE_LEN(5))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] observe(input int which);
        case (which)
            0:       return {ifa.output_signal, ifa.edge_flags, ifa.any_pulse};
            1:       return {ifb.output_signal, ifb.edge_flags, ifb.any_pulse};
            default: return {ifc.output_signal, ifc.edge_flags, ifc.any_pulse};
        endcase
    endfunction

    task automatic drive(input int which, input logic [3:0] in, input logic [1:0] m,
                         input logic [3:0] clr);
        case (which)
            0: begin ifa.input_signal = in; ifa.mode = m; ifa.clear_flags = clr; end
            1: begin ifb.input_signal = in; ifb.mode = m; ifb.clear_flags = clr; end
            default: begin ifc.input_signal = in; ifc.mode = m; ifc.clear_flags = clr; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 4'b0000, 2'b00, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sb_t        item;
        logic [8:0] got;
        rst = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 4'b1111, 2'b10, 4'b0000);
        for (int e = 1; e <= 3; e++) begin
            for (int w = 0; w < 3; w++) sb.push_back('{e, 9'b0});
            @(posedge clk);
            #1;
            for (int w = 0; w < 3; w++) begin
                item = sb.pop_front();
                got  = observe(w);
                tests_run++;
                if (got !== item.exp) begin
                    tests_failed++;
                    $display("FAIL reset dut%0d edge %0d: got %b expected %b", w, e, got, item.exp);
                end else $display("[TB] reset dut%0d edge %0d: %b ok", w, e, got);
            end
        end
    endtask

    task automatic test_rising();
        logic [3:0] eo, ef;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            drive(0, 4'b0001, 2'b00, 4'b0000);
            eo = (e == 4) ? 4'b0001 : 4'b0000;
            ef = (e >= 4) ? 4'b0001 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(0);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL rising edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] rising edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_falling();
        logic [3:0] eo, ef;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            drive(0, (e <= 6) ? 4'b0010 : 4'b0000, 2'b01, 4'b0000);
            eo = (e == 10) ? 4'b0010 : 4'b0000;
            ef = (e >= 10) ? 4'b0010 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(0);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL falling edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] falling edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_both_edges();
        logic [3:0] eo, ef;
        logic       lvl;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            lvl = (e <= 16) && (((e - 1) / 4) % 2 == 0);
            drive(0, lvl ? 4'b1001 : 4'b0000, 2'b10, 4'b0000);
            eo = (e == 4 || e == 8 || e == 12 || e == 16) ? 4'b1001 : 4'b0000;
            ef = (e >= 4) ? 4'b1001 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(0);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL both edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] both edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_disabled();
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            drive(0, (e <= 5) ? 4'b1111 : 4'b0000, 2'b11, 4'b0000);
            sb.push_back('{e, 9'b0});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(0);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL disabled edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] disabled edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_debounce();
        logic [3:0] eo, ef;
        logic       lvl;
        int         f;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        // Edges 1..12: 3-cycle glitch; edges 13..26: 4-cycle high accepted.
        for (int e = 1; e <= 26; e++) begin
            f   = (e <= 12) ? e : e - 12;
            lvl = (e <= 12) ? (f <= 3) : (f <= 4);
            drive(1, lvl ? 4'b0001 : 4'b0000, 2'b00, 4'b0000);
            eo = (e > 12 && f == 7) ? 4'b0001 : 4'b0000;
            ef = (e > 12 && f >= 7) ? 4'b0001 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(1);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL debounce edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] debounce edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_stretch();
        logic [3:0] eo, ef, in;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            in = {2'b00, 1'b1, (e <= 3)};
            drive(2, in, 2'b10, 4'b0000);
            eo = {2'b00, (e >= 4 && e <= 8), (e >= 4 && e <= 11)};
            ef = (e >= 4) ? 4'b0011 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(2);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL stretch edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] stretch edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_flag_clear();
        logic [3:0] eo, ef;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            drive(0, (e <= 4) ? 4'b0100 : 4'b0000, 2'b10,
                  (e == 8 || e == 9) ? 4'b0100 : 4'b0000);
            eo = (e == 4 || e == 8) ? 4'b0100 : 4'b0000;
            ef = (e >= 4 && e <= 8) ? 4'b0100 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(0);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL flag_clear edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] flag_clear edge %0d: %b ok", e, got);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] eo, ef;
        sb_t        item;
        logic [8:0] got;
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            rst = (e == 5);
            drive(2, 4'b0001, 2'b00, 4'b0000);
            eo = (e == 4 || (e >= 9 && e <= 13)) ? 4'b0001 : 4'b0000;
            ef = (e == 4 || e >= 9) ? 4'b0001 : 4'b0000;
            sb.push_back('{e, {eo, ef, |eo}});
            @(posedge clk);
            #1;
            item = sb.pop_front();
            got  = observe(2);
            tests_run++;
            if (got !== item.exp) begin
                tests_failed++;
                $display("FAIL reset_mid_pulse edge %0d: got %b expected %b", e, got, item.exp);
            end else $display("[TB] reset_mid_pulse edge %0d: %b ok", e, got);
        end
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 4'b0000, 2'b00, 4'b0000);
        #1;
        test_reset();
        test_rising();
        test_falling();
        test_both_edges();
        test_disabled();
        test_debounce();
        test_stretch();
        test_flag_clear();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
